countdown_timer: RTL and testbench

BCD mm:ss countdown timer. It is the down-counting counterpart of the clock's up-counting digit chain: it decrements four BCD digits once per second through a borrow chain instead of a carry chain. It sits beside the clock datapath, shares its 1 Hz prescaler style, and feeds the display mux and the alarm/buzzer logic. A small FSM handles load, start, pause, stop and expiry.

---
 rtl/countdown_pkg.sv | 24 ++
 rtl/countdown_timer_if.sv | 22 ++
 rtl/bcd_down_digit.sv | 22 ++
 rtl/countdown_timer.sv | 127 ++++++++++++
 tb/tb_countdown_timer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared encodings, BCD limits and helpers for the mm:ss countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int         NUM_DIGITS   = 4;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Lane 1 is sec_tens (0..5); every other lane is a plain decimal digit.
  function automatic logic [3:0] lane_max(input int i);
    return (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;
  endfunction

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the countdown timer and its host logic.
interface countdown_timer_if;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;
  logic [15:0] digits;
  logic [1:0]  state;
  logic        tick_o;
  logic        done_pulse;
  logic        alarm;

  modport master (
    output load, load_val, start, stop,
    input  digits, state, tick_o, done_pulse, alarm
  );

  modport slave (
    input  load, load_val, start, stop,
    output digits, state, tick_o, done_pulse, alarm
  );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of the borrow chain: loads, or decrements wrapping 0 -> MAX.
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] digit,
  output logic       borrow_o
);

  assign borrow_o = dec & (digit == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      digit <= '0;
    else if (ld)  digit <= ld_val;
    else if (dec) digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
  end

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown: control FSM, 1 Hz prescaler, four-digit borrow chain, expiry detect.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIV_W    = 26
) (
  input  logic             clk,
  input  logic             rst,
  countdown_timer_if.slave bus
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  state_t                       state_q, state_d;
  logic [DIV_W-1:0]             presc_q, presc_d;
  logic [NUM_DIGITS-1:0][3:0]   digit_q;
  logic [NUM_DIGITS-1:0][3:0]   ld_val_c;
  logic [NUM_DIGITS-1:0]        dec_c;
  logic [NUM_DIGITS-1:0]        borrow;
  logic                         ld, dec, tick_d, done_d;
  logic                         tick_q, done_q, alarm_q;
  logic                         nonzero, last_sec, wrap;
  logic                         unused_borrow;

  assign nonzero  = |digit_q;
  assign last_sec = (digit_q == 16'h0001);
  assign wrap     = (presc_q == PRESC_LAST);
  // min_tens never borrows: RUN is only entered with a nonzero value.
  assign unused_borrow = borrow[NUM_DIGITS-1];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign ld_val_c[i] = clamp_bcd(bus.load_val[i*4 +: 4], lane_max(i));
    if (i == 0) begin : g_lsd
      assign dec_c[i] = dec;
    end else begin : g_chain
      assign dec_c[i] = borrow[i-1];
    end
    bcd_down_digit #(.MAX(lane_max(i))) u_digit (
      .clk      (clk),
      .rst      (rst),
      .dec      (dec_c[i]),
      .ld       (ld),
      .ld_val   (ld_val_c[i]),
      .digit    (digit_q[i]),
      .borrow_o (borrow[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      alarm_q <= (state_d == EXPIRED);
    end
  end

  // Priority stop > load > start; stop in RUN also freezes the prescaler.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ld      = 1'b0;
    dec     = 1'b0;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.load) begin
          ld = 1'b1;
        end else if (bus.start && nonzero) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = PAUSE;
        end else if (wrap) begin
          presc_d = '0;
          dec     = 1'b1;
          tick_d  = 1'b1;
          if (last_sec) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.load) begin
          ld = 1'b1;
        end else if (bus.start && nonzero) begin
          state_d = RUN;
        end
      end
      EXPIRED: begin
        presc_d = '0;
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.load) begin
          ld      = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign bus.digits     = digit_q;
  assign bus.state      = state_q;
  assign bus.tick_o     = tick_q;
  assign bus.done_pulse = done_q;
  assign bus.alarm      = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench: stimulus queues expected tick snapshots, a monitor checks each tick_o.
module tb_countdown_timer;
  import countdown_pkg::*;

  typedef struct {
    int          cyc;
    logic [15:0] digits;
    logic [1:0]  state;
    logic        done;
    logic        alarm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   s, s2, e;

  countdown_timer_if bus();

  countdown_timer #(.TICK_DIV(4), .DIV_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every tick_o must match the oldest queued expectation, cycle included.
  always @(posedge clk) begin
    #1;
    if (bus.tick_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick cyc=%0d digits=%h state=%0d", cyc, bus.digits, bus.state);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || bus.digits !== mon_e.digits || bus.state !== mon_e.state ||
            bus.done_pulse !== mon_e.done || bus.alarm !== mon_e.alarm) begin
          errors++;
          $display("FAIL tick got cyc=%0d dig=%h st=%0d done=%b alarm=%b want cyc=%0d dig=%h st=%0d done=%b alarm=%b",
                   cyc, bus.digits, bus.state, bus.done_pulse, bus.alarm,
                   mon_e.cyc, mon_e.digits, mon_e.state, mon_e.done, mon_e.alarm);
        end
      end
    end else if (bus.done_pulse) begin
      checks++;
      errors++;
      $display("FAIL done_without_tick cyc=%0d got 1 want 0", cyc);
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic push(input int c, input logic [15:0] d, input state_t st, input logic dn, input logic al);
    exp_t x;
    x.cyc = c; x.digits = d; x.state = st; x.done = dn; x.alarm = al;
    sb.push_back(x);
  endtask

  // Stimulus always sits at a negedge; inputs set here are sampled at posedge cyc+1.
  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive_load(input logic [15:0] v);
    bus.load = 1'b1; bus.load_val = v;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic drive_start(output int edge_c);
    bus.start = 1'b1; edge_c = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drive_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0; bus.stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_digits", bus.digits, 16'h0000);
    chk("rst_state", 16'(bus.state), 16'(IDLE));
    chk("rst_tick", 16'(bus.tick_o), 16'h0);
    chk("rst_done", 16'(bus.done_pulse), 16'h0);
    chk("rst_alarm", 16'(bus.alarm), 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 01:00 borrows through sec_tens and min_ones
    drive_load(16'h0100);
    chk("t1_load", bus.digits, 16'h0100);
    drive_start(s);
    chk("t1_state", 16'(bus.state), 16'(RUN));
    push(s + 4, 16'h0059, RUN, 1'b0, 1'b0);
    push(s + 8, 16'h0058, RUN, 1'b0, 1'b0);
    wait_drain(20);
    drive_stop();
    chk("t1_pause", 16'(bus.state), 16'(PAUSE));
    drive_stop();
    chk("t1_idle", 16'(bus.state), 16'(IDLE));
    chk("t1_kept", bus.digits, 16'h0058);

    // 2: expiry, done pulse, alarm level, no ticks afterwards
    drive_load(16'h0002);
    drive_start(s);
    push(s + 4, 16'h0001, RUN, 1'b0, 1'b0);
    push(s + 8, 16'h0000, EXPIRED, 1'b1, 1'b1);
    wait_drain(20);
    @(negedge clk);
    chk("t2_done_once", 16'(bus.done_pulse), 16'h0);
    chk("t2_alarm", 16'(bus.alarm), 16'h1);
    chk("t2_state", 16'(bus.state), 16'(EXPIRED));
    goto(cyc + 10);
    chk("t2_digits", bus.digits, 16'h0000);
    chk("t2_alarm_held", 16'(bus.alarm), 16'h1);
    drive_stop();
    chk("t2_stop_state", 16'(bus.state), 16'(IDLE));
    chk("t2_stop_alarm", 16'(bus.alarm), 16'h0);

    // 3: pause keeps the prescaler phase (stop sampled at prescaler=2)
    drive_load(16'h0010);
    drive_start(s);
    push(s + 4, 16'h0009, RUN, 1'b0, 1'b0);
    goto(s + 6);
    drive_stop();
    chk("t3_pause", 16'(bus.state), 16'(PAUSE));
    chk("t3_frozen_a", bus.digits, 16'h0009);
    goto(cyc + 6);
    chk("t3_frozen_b", bus.digits, 16'h0009);
    drive_start(s2);
    push(s2 + 2, 16'h0008, RUN, 1'b0, 1'b0);
    wait_drain(10);
    drive_stop();
    drive_stop();
    chk("t3_idle", 16'(bus.state), 16'(IDLE));

    // 4: clamp on load, load ignored in RUN
    drive_load(16'hFA7C);
    chk("t4_clamp", bus.digits, 16'h9959);
    drive_start(s);
    drive_load(16'h0001);
    chk("t4_ld_ignored", bus.digits, 16'h9959);
    chk("t4_run", 16'(bus.state), 16'(RUN));
    push(s + 4, 16'h9958, RUN, 1'b0, 1'b0);
    wait_drain(10);
    drive_stop();
    drive_stop();

    // 5: start on zero ignored; start+stop together in PAUSE -> stop wins
    drive_load(16'h0000);
    drive_start(s);
    chk("t5_zero_start", 16'(bus.state), 16'(IDLE));
    drive_load(16'h0005);
    drive_start(s);
    drive_stop();
    chk("t5_pause", 16'(bus.state), 16'(PAUSE));
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("t5_stop_wins", 16'(bus.state), 16'(IDLE));
    chk("t5_digits", bus.digits, 16'h0005);

    // 6: asynchronous reset in the middle of RUN
    drive_load(16'h0131);
    drive_start(s);
    push(s + 4, 16'h0130, RUN, 1'b0, 1'b0);
    wait_drain(10);
    #2 rst = 1'b1;
    #1;
    chk("t6_digits", bus.digits, 16'h0000);
    chk("t6_state", 16'(bus.state), 16'(IDLE));
    chk("t6_tick", 16'(bus.tick_o), 16'h0);
    chk("t6_done", 16'(bus.done_pulse), 16'h0);
    chk("t6_alarm", 16'(bus.alarm), 16'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    e = cyc + 8;
    goto(e);
    chk("t6_stay_idle", 16'(bus.state), 16'(IDLE));

    chk("sb_empty", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
